// File: rtl/pwm_capture_if.sv
// pwm_capture_if: measurement result bundle of the PWM decoder.
// master drives the results, slave consumes them.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             timeout;
  logic             overrun;

  modport master (
    output period, high_time, duty_pct,
    output meas_valid, timeout, overrun
  );

  modport slave (
    input period, high_time, duty_pct,
    input meas_valid, timeout, overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty of a PWM line.
// Sync/edge detect, measurement FSM, 7-step restoring divider.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  pwm_capture_if.master mo
);

  localparam int W = CNT_W + 7;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, HIGH, LOW, STK_HI, STK_LO
  } state_t;

  state_t state, state_nx;

  logic s1, pwm_s, pwm_d;
  logic rise, fall;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic at_to;
  logic cap, stuck, stuck_hi, ok;

  logic             busy;
  logic [2:0]       idx;
  logic [W-1:0]     rem, dsh, num;
  logic [CNT_W-1:0] den, hi_r;
  logic [6:0]       quo;
  logic             take, last;

  logic [CNT_W-1:0] per_q, hi_q;
  logic [6:0]       duty_q;
  logic             mv_q, to_q, ov_q;

  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;
  assign at_to = (per_cnt == TO);
  assign num   = W'(hi_cnt) * W'(100);
  assign dsh   = W'(den) << idx;
  assign take  = (rem >= dsh);
  assign last  = busy && (idx == 3'd0);
  assign ok    = !busy && !mv_q;

  assign mo.period     = per_q;
  assign mo.high_time  = hi_q;
  assign mo.duty_pct   = duty_q;
  assign mo.meas_valid = mv_q;
  assign mo.timeout    = to_q;
  assign mo.overrun    = ov_q;

  // two-flop synchroniser plus one delay stage for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      s1    <= pwm_in;
      pwm_s <= s1;
      pwm_d <= pwm_s;
    end
  end

  // period counter saturates at TIMEOUT; high counter runs in HIGH
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      if (rise)
        per_cnt <= CNT_W'(1);
      else if (!at_to)
        per_cnt <= per_cnt + 1'b1;
      if (rise)
        hi_cnt <= CNT_W'(1);
      else if (state == HIGH && !fall)
        hi_cnt <= hi_cnt + 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state, capture and stuck-report decisions
  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    stuck    = 1'b0;
    stuck_hi = 1'b0;
    unique case (state)
      IDLE: if (rise) state_nx = HIGH;
      HIGH: begin
        if (fall) begin
          state_nx = LOW;
        end else if (at_to) begin
          stuck_hi = 1'b1;
          stuck    = ok;
          if (ok) state_nx = IDLE;
          else    state_nx = STK_HI;
        end
      end
      LOW: begin
        if (rise) begin
          cap      = 1'b1;
          state_nx = HIGH;
        end else if (at_to) begin
          stuck = ok;
          if (ok) state_nx = IDLE;
          else    state_nx = STK_LO;
        end
      end
      STK_HI: begin
        stuck_hi = 1'b1;
        stuck    = ok;
        if (ok) state_nx = IDLE;
      end
      STK_LO: begin
        stuck = ok;
        if (ok) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // restoring divider: one quotient bit per cycle, bit 6 first
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      idx  <= '0;
      rem  <= '0;
      den  <= '0;
      hi_r <= '0;
      quo  <= '0;
    end else if (cap && !busy) begin
      busy <= 1'b1;
      idx  <= 3'd6;
      rem  <= num;
      den  <= per_cnt;
      hi_r <= hi_cnt;
      quo  <= '0;
    end else if (busy) begin
      if (take) rem <= rem - dsh;
      quo[idx] <= take;
      idx      <= idx - 3'd1;
      if (idx == 3'd0) busy <= 1'b0;
    end
  end

  // result registers, valid pulse and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      per_q  <= '0;
      hi_q   <= '0;
      duty_q <= '0;
      mv_q   <= 1'b0;
      to_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      mv_q <= last | stuck;
      if (cap && busy) ov_q <= 1'b1;
      if (last) begin
        per_q  <= den;
        hi_q   <= hi_r;
        duty_q <= {quo[6:1], take};
        to_q   <= 1'b0;
      end else if (stuck) begin
        per_q  <= '0;
        hi_q   <= '0;
        duty_q <= stuck_hi ? 7'd100 : 7'd0;
        to_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random PWM waveforms checked
// against an event-time model of the capture rules.
module tb_pwm_capture;
  localparam int CNT_W = 16;
  localparam int TO    = 200;

  typedef struct {
    int t;
    int per;
    int hi;
    int duty;
    bit to;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic pwm_in;

  pwm_capture_if #(.CNT_W(CNT_W)) mi ();

  pwm_capture #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .mo    (mi)
  );

  always #5 clk = ~clk;

  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  p1, p2;
  bit  armed, pend;
  int  pend_until, last_rise, last_fall, last_cap, ov_from;
  ev_t evq[$];
  int  e_per, e_hi, e_duty;
  bit  e_to, e_mv;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    armed      = 1'b0;
    pend       = 1'b0;
    pend_until = 0;
    last_rise  = 0;
    last_fall  = 0;
    last_cap   = -100;
    ov_from    = 1 << 30;
    evq.delete();
    e_per  = 0;
    e_hi   = 0;
    e_duty = 0;
    e_to   = 1'b0;
    p1     = 1'b0;
    p2     = 1'b0;
  endfunction

  // s/d: synchronised level this cycle and the cycle before
  function automatic void mdl_cycle(input bit s, input bit d);
    bit r, f;
    int per, hi, t;
    r = s & ~d;
    f = ~s & d;
    if (pend && cyc >= pend_until) pend = 1'b0;
    if (f) last_fall = cyc;
    if (pend) return;
    if (r) begin
      if (armed) begin
        per = (cyc - last_rise < TO) ? cyc - last_rise : TO;
        hi  = last_fall - last_rise;
        if (cyc >= last_cap + 8) begin
          evq.push_back('{cyc + 8, per, hi, hi * 100 / per, 1'b0});
          last_cap = cyc;
        end else if (ov_from > cyc + 1) begin
          ov_from = cyc + 1;
        end
      end
      armed     = 1'b1;
      last_rise = cyc;
    end else if (armed && !f && cyc - last_rise >= TO) begin
      t = (cyc + 1 > last_cap + 10) ? cyc + 1 : last_cap + 10;
      evq.push_back('{t, 0, 0, s ? 100 : 0, 1'b1});
      pend       = 1'b1;
      pend_until = t;
      armed      = 1'b0;
    end
  endfunction

  task automatic step(input bit lv);
    pwm_in = lv;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mdl_reset();
    end else begin
      mdl_cycle(p1, p2);
      p2 = p1;
      p1 = lv;
    end
    e_mv = 1'b0;
    if (evq.size() > 0 && evq[0].t == cyc) begin
      e_mv   = 1'b1;
      e_per  = evq[0].per;
      e_hi   = evq[0].hi;
      e_duty = evq[0].duty;
      e_to   = evq[0].to;
      evq.delete(0);
    end
    @(negedge clk);
    chk("meas_valid", 32'(mi.meas_valid), 32'(e_mv));
    chk("period", 32'(mi.period), 32'(e_per));
    chk("high_time", 32'(mi.high_time), 32'(e_hi));
    chk("duty_pct", 32'(mi.duty_pct), 32'(e_duty));
    chk("timeout", 32'(mi.timeout), 32'(e_to));
    chk("overrun", 32'(mi.overrun), 32'(cyc >= ov_from));
  endtask

  task automatic pulse(input int h, input int l);
    repeat (h) step(1'b1);
    repeat (l) step(1'b0);
  endtask

  task automatic hold(input bit lv, input int n);
    repeat (n) step(lv);
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    mdl_reset();
    @(negedge clk);
    hold(1'b0, 3);
    rst = 1'b0;

    repeat (4) pulse(25, 75);
    chk("steady period", 32'(mi.period), 32'd100);
    chk("steady high", 32'(mi.high_time), 32'd25);
    chk("steady duty", 32'(mi.duty_pct), 32'd25);
    chk("steady overrun", 32'(mi.overrun), 32'd0);

    pulse(1, 99);
    pulse(99, 1);
    chk("duty 1/100", 32'(mi.duty_pct), 32'd1);
    pulse(1, 20);
    chk("duty 99/100", 32'(mi.duty_pct), 32'd99);

    hold(1'b0, 230);
    chk("stuck low to", 32'(mi.timeout), 32'd1);
    chk("stuck low duty", 32'(mi.duty_pct), 32'd0);
    chk("stuck low per", 32'(mi.period), 32'd0);

    pulse(1, 1);
    pulse(1, 20);
    chk("duty 1/2", 32'(mi.duty_pct), 32'd50);
    chk("per 2", 32'(mi.period), 32'd2);
    chk("to cleared", 32'(mi.timeout), 32'd0);
    chk("no overrun yet", 32'(mi.overrun), 32'd0);

    pulse(25, 75);
    pulse(25, 75);
    hold(1'b1, 250);
    chk("stuck high to", 32'(mi.timeout), 32'd1);
    chk("stuck high duty", 32'(mi.duty_pct), 32'd100);
    hold(1'b0, 30);

    repeat (3) pulse(3, 4);
    pulse(3, 20);
    chk("per 7", 32'(mi.period), 32'd7);
    chk("duty 3/7", 32'(mi.duty_pct), 32'd42);
    chk("overrun set", 32'(mi.overrun), 32'd1);

    repeat (40)
      pulse(int'($urandom_range(30, 1)), int'($urandom_range(30, 1)));

    pulse(10, 10);
    pulse(10, 10);
    hold(1'b1, 5);
    rst = 1'b1;
    hold(1'b0, 3);
    rst = 1'b0;
    step(1'b0);
    chk("rst overrun", 32'(mi.overrun), 32'd0);
    chk("rst period", 32'(mi.period), 32'd0);
    chk("rst duty", 32'(mi.duty_pct), 32'd0);
    hold(1'b0, 10);

    repeat (3) pulse(20, 20);
    chk("after rst per", 32'(mi.period), 32'd40);
    chk("after rst high", 32'(mi.high_time), 32'd20);
    chk("after rst duty", 32'(mi.duty_pct), 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
